// File: rtl/alarm_timer_pkg.sv
// Shared constants and types for the multi-channel alarm timer.
// Build option: define ALARM_TIMER_CHAIN_EN to enable cascaded channel chaining.
package alarm_timer_pkg;

  localparam logic [1:0] REG_STATUS  = 2'd0;
  localparam logic [1:0] REG_CONTROL = 2'd1;
  localparam logic [1:0] REG_PERIOD  = 2'd2;
  localparam logic [1:0] REG_SNAP    = 2'd3;

  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;
  localparam int CTRL_CHAIN = 4;
  localparam int CTRL_W     = 5;

`ifdef ALARM_TIMER_CHAIN_EN
  localparam bit CHAIN_EN = 1'b1;
`else
  localparam bit CHAIN_EN = 1'b0;
`endif

  typedef struct packed {
    logic running;
    logic timeout;
    logic zero_d;
    logic force_reload;
  } chan_state_t;

  function automatic logic [31:0] status_word(input chan_state_t s);
    return {30'b0, s.running, s.timeout};
  endfunction

endpackage

// File: rtl/alarm_timer_chan.sv
// One timer channel: down-counter, run/timeout control, and its four registers.
// CHAIN_OK is set only for channels that may follow the previous channel's timeouts.
module alarm_timer_chan
  import alarm_timer_pkg::*;
#(
  parameter int          COUNT_W      = 32,
  parameter logic [31:0] RESET_PERIOD = 32'h02FA_F07F,
  parameter bit          CHAIN_OK     = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_status,
  input  logic        wr_control,
  input  logic        wr_period,
  input  logic        wr_snap,
  input  logic [31:0] writedata,
  input  logic        tick_in,
  input  logic [1:0]  rd_offset,
  output logic [31:0] rd_data,
  output logic        timeout_event,
  output logic        irq
);

  localparam logic [COUNT_W-1:0] RST_VAL = RESET_PERIOD[COUNT_W-1:0];

  logic [COUNT_W-1:0] counter;
  logic [COUNT_W-1:0] period;
  logic [COUNT_W-1:0] snapshot;
  logic [CTRL_W-1:0]  control;
  logic [CTRL_W-1:0]  ctrl_wmask;
  chan_state_t        st;
  chan_state_t        st_next;
  logic               cnt_zero;
  logic               tick;
  logic               step;
  logic               start_wr;
  logic               stop_wr;
  logic [31:0]        period_x;
  logic [31:0]        snapshot_x;

  assign ctrl_wmask    = {CHAIN_OK, 4'hF};
  assign cnt_zero      = (counter == '0);
  assign tick          = control[CTRL_CHAIN] ? tick_in : 1'b1;
  assign step          = (st.running && tick) || st.force_reload;
  assign timeout_event = cnt_zero && !st.zero_d;
  assign start_wr      = wr_control && writedata[CTRL_START];
  assign stop_wr       = wr_control && writedata[CTRL_STOP];
  assign irq           = st.timeout && control[CTRL_ITO];

  // Later assignments take priority: START beats any stop cause, a timeout beats a clear.
  always_comb begin
    st_next              = st;
    st_next.force_reload = wr_period;
    st_next.zero_d       = cnt_zero;
    if (stop_wr || st.force_reload || (step && cnt_zero && !control[CTRL_CONT]))
      st_next.running = 1'b0;
    if (start_wr)
      st_next.running = 1'b1;
    if (wr_status)
      st_next.timeout = 1'b0;
    if (timeout_event)
      st_next.timeout = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st <= '0;
    end else begin
      st <= st_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      counter <= RST_VAL;
    end else if (step) begin
      counter <= (cnt_zero || st.force_reload) ? period : counter - COUNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period   <= RST_VAL;
      control  <= '0;
      snapshot <= '0;
    end else begin
      if (wr_period)
        period <= writedata[COUNT_W-1:0];
      if (wr_control)
        control <= writedata[CTRL_W-1:0] & ctrl_wmask;
      if (wr_snap)
        snapshot <= counter;
    end
  end

  always_comb begin
    period_x                  = '0;
    period_x[COUNT_W-1:0]     = period;
    snapshot_x                = '0;
    snapshot_x[COUNT_W-1:0]   = snapshot;
  end

  always_comb begin
    rd_data = '0;
    case (rd_offset)
      REG_STATUS:  rd_data = status_word(st);
      REG_CONTROL: rd_data = {{(32-CTRL_W){1'b0}}, control};
      REG_PERIOD:  rd_data = period_x;
      REG_SNAP:    rd_data = snapshot_x;
      default:     rd_data = '0;
    endcase
  end

endmodule

// File: rtl/alarm_timer_mc.sv
// Multi-channel interval timer with Avalon-MM slave: decode, read register, irq merge.
// Build option: ALARM_TIMER_CHAIN_EN lets channel i count on channel i-1 timeouts.
module alarm_timer_mc
  import alarm_timer_pkg::*;
#(
  parameter int          NUM_CH       = 4,
  parameter int          COUNT_W      = 32,
  parameter logic [31:0] RESET_PERIOD = 32'h02FA_F07F,
  localparam int         AW           = $clog2(NUM_CH) + 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [AW-1:0]     address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [NUM_CH-1:0] irq,
  output logic              irq_any
);

  logic [AW-1:0]     ch_sel;
  logic [1:0]        offset;
  logic              wr_en;
  logic [31:0]       rd_vec [NUM_CH];
  logic [NUM_CH-1:0] tev;
  logic [NUM_CH-1:0] tick;
  logic [31:0]       rd_mux_p0;
  logic [31:0]       rdata_p1;

  assign ch_sel = address >> 2;
  assign offset = address[1:0];
  assign wr_en  = chipselect && !write_n;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic sel;
    assign sel = wr_en && (ch_sel == AW'(i));

    // Channel 0 can never set CHAIN, so closing the ring there is inert.
    if (i == 0) begin : g_tick0
      assign tick[i] = tev[NUM_CH-1];
    end else begin : g_tickn
      assign tick[i] = tev[i-1];
    end

    alarm_timer_chan #(
      .COUNT_W      (COUNT_W),
      .RESET_PERIOD (RESET_PERIOD),
      .CHAIN_OK     (CHAIN_EN && (i != 0))
    ) u_chan (
      .clk           (clk),
      .reset_n       (reset_n),
      .wr_status     (sel && (offset == REG_STATUS)),
      .wr_control    (sel && (offset == REG_CONTROL)),
      .wr_period     (sel && (offset == REG_PERIOD)),
      .wr_snap       (sel && (offset == REG_SNAP)),
      .writedata     (writedata),
      .tick_in       (tick[i]),
      .rd_offset     (offset),
      .rd_data       (rd_vec[i]),
      .timeout_event (tev[i]),
      .irq           (irq[i])
    );
  end

  // Out-of-range channel indices match no channel and read as zero.
  always_comb begin
    rd_mux_p0 = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == AW'(i))
        rd_mux_p0 = rd_vec[i];
    end
  end

  // p0 -> p1: read data register, loaded every cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_p1 <= '0;
    end else begin
      rdata_p1 <= rd_mux_p0;
    end
  end

  assign readdata = rdata_p1;
  assign irq_any  = |irq;

endmodule

// File: tb/tb_alarm_timer_mc.sv
// Self-checking bench for alarm_timer_mc (3 channels so an out-of-range index exists).
module tb_alarm_timer_mc;

  localparam int NUM_CH = 3;
  localparam int AW     = $clog2(NUM_CH) + 2;
  localparam logic [31:0] RST_P = 32'h02FA_F07F;

  logic              clk;
  logic              reset_n;
  logic [AW-1:0]     address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic [NUM_CH-1:0] irq;
  logic              irq_any;

  int n_total = 0;
  int n_bad   = 0;

  logic [31:0] exp_q [$];
  string       nm_q  [$];

  typedef struct {
    logic        we;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
    string       nm;
  } vec_t;

  vec_t tbl [9];

  alarm_timer_mc #(.NUM_CH(NUM_CH), .COUNT_W(32), .RESET_PERIOD(RST_P)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .irq_any    (irq_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [3:0] A(input int ch, input int off);
    return 4'((ch << 2) | off);
  endfunction

  function automatic vec_t mkv(input logic we, input logic [3:0] a, input logic [31:0] d,
                               input logic [31:0] e, input string nm);
    vec_t v;
    v.we = we; v.addr = a; v.data = d; v.exp = e; v.nm = nm;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Called at a negedge; the write lands on the following posedge.
  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] e, input string nm);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    exp_q.push_back(e);
    nm_q.push_back(nm);
    @(negedge clk);
    chipselect = 1'b0;
    chk(nm_q.pop_front(), readdata, exp_q.pop_front());
  endtask

  initial begin
    int k;
    logic early;

    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
    repeat (3) @(negedge clk);
    chk("rst_readdata", readdata, 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_irq_any", 32'(irq_any), 32'h0);
    reset_n = 1'b1;

    tbl[0] = mkv(1'b0, A(0, 2), 32'h0,         RST_P,         "ch0_period_rst");
    tbl[1] = mkv(1'b0, A(0, 0), 32'h0,         32'h0,         "ch0_status_rst");
    tbl[2] = mkv(1'b0, A(2, 3), 32'h0,         32'h0,         "ch2_snap_rst");
    tbl[3] = mkv(1'b0, A(1, 1), 32'h0,         32'h0,         "ch1_control_rst");
    tbl[4] = mkv(1'b1, A(2, 1), 32'h0000_0001, 32'h0,         "");
    tbl[5] = mkv(1'b0, A(2, 1), 32'h0,         32'h0000_0001, "ch2_control_rb");
    tbl[6] = mkv(1'b1, A(2, 2), 32'hABCD_1234, 32'h0,         "");
    tbl[7] = mkv(1'b0, A(2, 2), 32'h0,         32'hABCD_1234, "ch2_period_rb");
    tbl[8] = mkv(1'b0, A(2, 0), 32'h0,         32'h0,         "ch2_status_idle");
    for (int i = 0; i < 9; i++) begin
      if (tbl[i].we) wr(tbl[i].addr, tbl[i].data);
      else           rd(tbl[i].addr, tbl[i].exp, tbl[i].nm);
    end

    // ch1 one-shot, period 5
    wr(A(1, 2), 32'd5);
    wr(A(1, 1), 32'h5);
    early = 1'b0;
    for (int i = 0; i < 6; i++) begin
      early = early | irq[1];
      @(negedge clk);
    end
    chk("ch1_irq_early", 32'(early), 32'h0);
    chk("ch1_irq_at_6", 32'(irq[1]), 32'h1);
    chk("irq_any_ch1", 32'(irq_any), 32'h1);
    rd(A(1, 0), 32'h1, "ch1_status_oneshot");

    // ch2 continuous, period 3
    wr(A(2, 2), 32'd3);
    wr(A(2, 1), 32'h7);
    k = 0;
    while (!irq[2] && k < 20) begin @(negedge clk); k++; end
    chk("ch2_first_event", 32'(k), 32'd4);
    wr(A(2, 0), 32'h0);
    chk("ch2_status_clear", 32'(irq[2]), 32'h0);
    repeat (2) @(negedge clk);
    wr(A(2, 0), 32'h0);
    chk("ch2_clear_vs_event", 32'(irq[2]), 32'h1);
    wr(A(2, 0), 32'h0);
    k = 0;
    while (!irq[2] && k < 20) begin @(negedge clk); k++; end
    chk("ch2_event_interval", 32'(k), 32'd3);

    // ch0 snapshot and mid-count period write
    wr(A(0, 2), 32'd10);
    wr(A(0, 1), 32'h6);
    repeat (3) @(negedge clk);
    wr(A(0, 3), 32'h0);
    rd(A(0, 3), 32'd7, "ch0_snap_live");
    rd(A(0, 0), 32'h2, "ch0_running");
    wr(A(0, 2), 32'd20);
    @(negedge clk);
    rd(A(0, 0), 32'h0, "ch0_stop_on_period");
    wr(A(0, 3), 32'h0);
    rd(A(0, 3), 32'd20, "ch0_reloaded");

    // START|STOP together, then out-of-range channel
    wr(A(0, 1), 32'hC);
    rd(A(0, 0), 32'h2, "start_beats_stop");
    rd(A(0, 1), 32'hC, "ch0_control_rb");
    wr(A(3, 2), 32'h55);
    wr(A(3, 1), 32'h7);
    rd(A(3, 2), 32'h0, "oor_period_read");
    rd(A(3, 0), 32'h0, "oor_status_read");
    rd(A(2, 2), 32'd3, "oor_no_effect_ch2");
    rd(A(0, 2), 32'd20, "oor_no_effect_ch0");

    // period 0 continuous: one timeout, no re-fire
    wr(A(1, 0), 32'h0);
    chk("ch1_cleared", 32'(irq[1]), 32'h0);
    wr(A(1, 2), 32'd0);
    wr(A(1, 1), 32'h7);
    repeat (3) @(negedge clk);
    chk("ch1_p0_fires", 32'(irq[1]), 32'h1);
    wr(A(1, 0), 32'h0);
    early = 1'b0;
    for (int i = 0; i < 8; i++) begin
      early = early | irq[1];
      @(negedge clk);
    end
    chk("ch1_p0_no_refire", 32'(early), 32'h0);
    rd(A(1, 0), 32'h2, "ch1_p0_running");

    // CHAIN bit storage
    wr(A(0, 1), 32'h10);
    rd(A(0, 1), 32'h0, "ch0_chain_rd0");
    wr(A(1, 1), 32'h10);
`ifdef ALARM_TIMER_CHAIN_EN
    rd(A(1, 1), 32'h10, "ch1_chain_bit");
    wr(A(0, 2), 32'd1);
    wr(A(0, 1), 32'h6);
    wr(A(1, 2), 32'd2);
    wr(A(1, 1), 32'h17);
    k = 0;
    while (!irq[1] && k < 30) begin @(negedge clk); k++; end
    chk("ch1_chain_not_early", 32'(k >= 4), 32'h1);
    chk("ch1_chain_in_time", 32'(k <= 8), 32'h1);
`else
    rd(A(1, 1), 32'h0, "ch1_chain_bit");
`endif

    // asynchronous reset mid-count
    rd(A(2, 2), 32'd3, "ch2_period_pre_rst");
    reset_n = 1'b0;
    #1;
    chk("midrst_readdata", readdata, 32'h0);
    chk("midrst_irq", 32'(irq), 32'h0);
    chk("midrst_irq_any", 32'(irq_any), 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    rd(A(2, 2), RST_P, "postrst_ch2_period");
    rd(A(2, 0), 32'h0, "postrst_ch2_status");
    rd(A(0, 1), 32'h0, "postrst_ch0_control");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
